// File: rtl/tl_fft_extn_loader.sv
// ---------------------------------------------------------------------------
// tl_fft_extn_loader
//
// Write-side sequencer for the 8-bank sample memory. Accepts 8-lane x 64-bit
// beats from the external port (valid/ready), registers them onto the
// interface stage's D*_EXTN inputs, and issues a common write enable and
// address to all banks. Each row carries a lane rotation (SEL_PERMW) equal to
// the mod-8 sum of the 3-bit digits of its beat index, which skews the rows so
// that later column reads hit every bank exactly once. One frame is 2**AW
// beats; DONE pulses together with the WE of the last row.
//
// Ports:
//   CLK, RSTN            clock, asynchronous active-low reset
//   START, BASE_ADDR     begin a frame (IDLE only), bank address of beat 0
//   ABORT                cancel the frame in progress
//   IN_VALID, IN_READY   beat handshake; IN_READY depends on state and ABORT
//   IN_D0..IN_D7         lane data of the incoming beat
//   D0_EXTN..D7_EXTN     registered lane data to the interface stage
//   SEL_EXTN             0 while loading (external path), 1 when released
//   SEL_PERMW            lane rotation of the registered row
//   WE, WADDR            common bank write enable and address
//   BUSY                 frame in progress
//   DONE                 one-cycle pulse with the last WE of a frame
// ---------------------------------------------------------------------------
module tl_fft_extn_loader #(
    parameter int AW = 6
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START,
    input  logic [AW-1:0] BASE_ADDR,
    input  logic          ABORT,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [63:0]   IN_D0,
    input  logic [63:0]   IN_D1,
    input  logic [63:0]   IN_D2,
    input  logic [63:0]   IN_D3,
    input  logic [63:0]   IN_D4,
    input  logic [63:0]   IN_D5,
    input  logic [63:0]   IN_D6,
    input  logic [63:0]   IN_D7,
    output logic [63:0]   D0_EXTN,
    output logic [63:0]   D1_EXTN,
    output logic [63:0]   D2_EXTN,
    output logic [63:0]   D3_EXTN,
    output logic [63:0]   D4_EXTN,
    output logic [63:0]   D5_EXTN,
    output logic [63:0]   D6_EXTN,
    output logic [63:0]   D7_EXTN,
    output logic          SEL_EXTN,
    output logic [2:0]    SEL_PERMW,
    output logic          WE,
    output logic [AW-1:0] WADDR,
    output logic          BUSY,
    output logic          DONE
);

    // Beat index split into 3-bit digits; short indices are zero-padded.
    localparam int ND = (AW + 2) / 3;
    localparam int PW = ND * 3;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] beat_reg, beat_next;
    logic [AW-1:0] base_reg, base_next;

    logic          accept;
    logic          last_beat;

    logic [63:0]   lane_in  [8];
    logic [63:0]   lane_reg [8];

    logic [PW-1:0] beat_pad;
    logic [2:0]    rot_acc [ND+1];

    logic          we_reg;
    logic          done_reg;
    logic [AW-1:0] waddr_reg;
    logic [2:0]    perm_reg;
    logic          busy_reg;
    logic          sel_extn_reg;

    // ---------------------------------------------------------------------
    // Handshake: ready never looks at IN_VALID, so no combinational loop
    // can form through an upstream that gates valid on ready.
    // ---------------------------------------------------------------------
    assign IN_READY  = (state_reg == S_LOAD) && !ABORT;
    assign accept    = IN_VALID && IN_READY;
    assign last_beat = (beat_reg == {AW{1'b1}});

    // ---------------------------------------------------------------------
    // Row rotation: digit sum of the beat index, wrapping mod 8 in 3 bits.
    // ---------------------------------------------------------------------
    assign beat_pad   = PW'(beat_reg);
    assign rot_acc[0] = 3'd0;

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_digit
            assign rot_acc[gi+1] = rot_acc[gi] + beat_pad[3*gi +: 3];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // State machine
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg <= S_IDLE;
            beat_reg  <= '0;
            base_reg  <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            base_reg  <= base_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        base_next  = base_reg;
        case (state_reg)
            S_IDLE: begin
                // ABORT has no meaning here; START always wins.
                if (START) begin
                    state_next = S_LOAD;
                    beat_next  = '0;
                    base_next  = BASE_ADDR;
                end
            end
            S_LOAD: begin
                if (ABORT) begin
                    state_next = S_IDLE;
                end else if (accept) begin
                    beat_next = beat_reg + 1'b1;
                    if (last_beat) begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Register stage toward the banks. Data, address and rotation hold
    // through bubbles; only WE/DONE drop.
    // ---------------------------------------------------------------------
    assign lane_in[0] = IN_D0;
    assign lane_in[1] = IN_D1;
    assign lane_in[2] = IN_D2;
    assign lane_in[3] = IN_D3;
    assign lane_in[4] = IN_D4;
    assign lane_in[5] = IN_D5;
    assign lane_in[6] = IN_D6;
    assign lane_in[7] = IN_D7;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    lane_reg[gi] <= '0;
                end else if (accept) begin
                    lane_reg[gi] <= lane_in[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            we_reg       <= 1'b0;
            done_reg     <= 1'b0;
            waddr_reg    <= '0;
            perm_reg     <= '0;
            busy_reg     <= 1'b0;
            sel_extn_reg <= 1'b1;
        end else begin
            we_reg       <= accept;
            done_reg     <= accept && last_beat;
            busy_reg     <= (state_next == S_LOAD);
            sel_extn_reg <= (state_next != S_LOAD);
            if (accept) begin
                // Address wraps silently modulo the bank depth.
                waddr_reg <= base_reg + beat_reg;
                perm_reg  <= rot_acc[ND];
            end
        end
    end

    assign D0_EXTN   = lane_reg[0];
    assign D1_EXTN   = lane_reg[1];
    assign D2_EXTN   = lane_reg[2];
    assign D3_EXTN   = lane_reg[3];
    assign D4_EXTN   = lane_reg[4];
    assign D5_EXTN   = lane_reg[5];
    assign D6_EXTN   = lane_reg[6];
    assign D7_EXTN   = lane_reg[7];
    assign WE        = we_reg;
    assign DONE      = done_reg;
    assign WADDR     = waddr_reg;
    assign SEL_PERMW = perm_reg;
    assign BUSY      = busy_reg;
    assign SEL_EXTN  = sel_extn_reg;

endmodule
